// File: rtl/demux_1x4_buffered_if.sv
// Producer/consumer bundle for the buffered 1-to-4 demux: one input handshake,
// four output channels sharing a valid/ready vector.
interface demux_1x4_buffered_if #(
    parameter int WIDTH = 32
);
    logic             S0;
    logic             S1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] R0;
    logic [WIDTH-1:0] R1;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] R3;

    modport master (
        output S0, S1, in_valid, in_data, out_ready,
        input  in_ready, out_valid, R0, R1, R2, R3
    );

    modport slave (
        input  S0, S1, in_valid, in_data, out_ready,
        output in_ready, out_valid, R0, R1, R2, R3
    );
endinterface

// File: rtl/demux_1x4_buffered.sv
// Clocked 1-to-4 demultiplexer with a one-entry buffer per output channel and
// a wrapping count of accepted words.
module demux_1x4_buffered #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    demux_1x4_buffered_if.slave  bus,
    output logic [CNT_W-1:0]     xfer_count,
    output logic                 busy
);

    logic [1:0]       sel;
    logic             in_ready;
    logic             accept;
    logic [3:0]       valid_q;
    logic [WIDTH-1:0] data_q [4];
    logic [CNT_W-1:0] count_q;

    assign sel = {bus.S1, bus.S0};

    // A full channel can still take a word if its consumer drains it on the same edge.
    assign in_ready = !reset && (!valid_q[sel] || bus.out_ready[sel]);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && (sel == 2'(k))) begin
                    data_q[k]  <= bus.in_data;
                    valid_q[k] <= 1'b1;
                end else if (bus.out_ready[k]) begin
                    valid_q[k] <= 1'b0;
                end
            end
            if (accept) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = valid_q;
    assign bus.R0        = data_q[0];
    assign bus.R1        = data_q[1];
    assign bus.R2        = data_q[2];
    assign bus.R3        = data_q[3];
    assign xfer_count    = count_q;
    assign busy          = |valid_q;

endmodule

// File: tb/tb_demux_1x4_buffered.sv
// Bench for demux_1x4_buffered: per-channel scoreboard queues fed on predicted
// accepts and drained on predicted consumer handshakes, plus directed scenarios.
module tb_demux_1x4_buffered;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  xfer_count;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic        mon_en = 1'b0;
    logic [3:0]  m_valid = '0;
    logic [7:0]  m_count = '0;
    logic [31:0] sb [4][$];
    logic [31:0] r_arr [4];

    demux_1x4_buffered_if #(.WIDTH(32)) bus ();

    demux_1x4_buffered #(.WIDTH(32), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .xfer_count (xfer_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign r_arr[0] = bus.R0;
    assign r_arr[1] = bus.R1;
    assign r_arr[2] = bus.R2;
    assign r_arr[3] = bus.R3;

    // Scoreboard: compare against the model before the coming edge, then advance the model.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] s;
            logic       exp_ready;
            s         = {bus.S1, bus.S0};
            exp_ready = !reset && (!m_valid[s] || bus.out_ready[s]);
            checks++;
            if (bus.in_ready !== exp_ready) begin
                errors++;
                $display("[TB] FAIL sb_in_ready: got %b expected %b at %0t", bus.in_ready, exp_ready, $time);
            end
            checks++;
            if (bus.out_valid !== m_valid) begin
                errors++;
                $display("[TB] FAIL sb_out_valid: got %b expected %b at %0t", bus.out_valid, m_valid, $time);
            end
            checks++;
            if (busy !== (|m_valid)) begin
                errors++;
                $display("[TB] FAIL sb_busy: got %b expected %b at %0t", busy, |m_valid, $time);
            end
            checks++;
            if (xfer_count !== m_count) begin
                errors++;
                $display("[TB] FAIL sb_xfer_count: got %0d expected %0d at %0t", xfer_count, m_count, $time);
            end
            for (int k = 0; k < 4; k++) begin
                if (m_valid[k] && sb[k].size() > 0) begin
                    checks++;
                    if (r_arr[k] !== sb[k][0]) begin
                        errors++;
                        $display("[TB] FAIL sb_R%0d: got %h expected %h at %0t", k, r_arr[k], sb[k][0], $time);
                    end
                end
            end
            if (reset) begin
                m_valid = '0;
                m_count = '0;
                for (int k = 0; k < 4; k++) sb[k].delete();
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (m_valid[k] && bus.out_ready[k]) begin
                        void'(sb[k].pop_front());
                        m_valid[k] = 1'b0;
                    end
                end
                if (bus.in_valid && exp_ready) begin
                    sb[s].push_back(bus.in_data);
                    m_valid[s] = 1'b1;
                    m_count    = m_count + 8'd1;
                end
            end
        end
    end

    task automatic drive(input logic rst, input logic v, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] rdy);
        @(posedge clk);
        #1;
        reset        = rst;
        bus.in_valid = v;
        bus.S1       = s[1];
        bus.S0       = s[0];
        bus.in_data  = d;
        bus.out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0000", bus.out_valid); end
        checks++; if (xfer_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_xfer_count: got %0d expected 0", xfer_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (r_arr[k] !== 32'h0) begin errors++; $display("[TB] FAIL reset_R%0d: got %h expected 0", k, r_arr[k]); end
        end
        mon_en = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
    endtask

    task automatic test_routing();
        logic [31:0] words [4];
        words[0] = 32'h1111_1111;
        words[1] = 32'h2222_2222;
        words[2] = 32'h3333_3333;
        words[3] = 32'h4444_4444;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 2'(i), words[i], 4'b1111);
            if (i > 0) begin
                checks++;
                if (bus.out_valid !== (4'b0001 << (i - 1))) begin
                    errors++;
                    $display("[TB] FAIL routing_out_valid%0d: got %b expected %b", i, bus.out_valid, 4'b0001 << (i - 1));
                end
            end
            checks++;
            if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL routing_in_ready%0d: got %b expected 1", i, bus.in_ready); end
        end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        checks++; if (bus.out_valid !== 4'b1000) begin errors++; $display("[TB] FAIL routing_last_valid: got %b expected 1000", bus.out_valid); end
        checks++; if (bus.R3 !== 32'h4444_4444) begin errors++; $display("[TB] FAIL routing_R3: got %h expected 44444444", bus.R3); end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        checks++; if (xfer_count !== 8'd4) begin errors++; $display("[TB] FAIL routing_count: got %0d expected 4", xfer_count); end
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL routing_drained: got %b expected 0000", bus.out_valid); end
        checks++; if (bus.R0 !== 32'h1111_1111) begin errors++; $display("[TB] FAIL routing_R0_kept: got %h expected 11111111", bus.R0); end
    endtask

    task automatic test_stall();
        drive(1'b0, 1'b1, 2'd2, 32'hAAAA_AAAA, 4'b0000);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_first_ready: got %b expected 1", bus.in_ready); end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 2'd2, 32'hBBBB_BBBB, 4'b0000);
            checks++; if (bus.out_valid !== 4'b0100) begin errors++; $display("[TB] FAIL stall_valid%0d: got %b expected 0100", i, bus.out_valid); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_ready%0d: got %b expected 0", i, bus.in_ready); end
            checks++; if (bus.R2 !== 32'hAAAA_AAAA) begin errors++; $display("[TB] FAIL stall_R2_%0d: got %h expected aaaaaaaa", i, bus.R2); end
        end
        drive(1'b0, 1'b1, 2'd0, 32'hBBBB_BBBB, 4'b0000);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL stall_resel_ready: got %b expected 1", bus.in_ready); end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        checks++; if (bus.out_valid !== 4'b0101) begin errors++; $display("[TB] FAIL stall_resel_valid: got %b expected 0101", bus.out_valid); end
        checks++; if (bus.R0 !== 32'hBBBB_BBBB) begin errors++; $display("[TB] FAIL stall_R0: got %h expected bbbbbbbb", bus.R0); end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL stall_drained: got %b expected 0000", bus.out_valid); end
    endtask

    task automatic test_drain_load();
        logic [7:0] exp_cnt;
        exp_cnt = m_count + 8'd2;
        drive(1'b0, 1'b1, 2'd1, 32'h5, 4'b0000);
        drive(1'b0, 1'b1, 2'd1, 32'h6, 4'b0010);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL drain_load_ready: got %b expected 1", bus.in_ready); end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        checks++; if (bus.R1 !== 32'h6) begin errors++; $display("[TB] FAIL drain_load_R1: got %h expected 6", bus.R1); end
        checks++; if (bus.out_valid !== 4'b0010) begin errors++; $display("[TB] FAIL drain_load_valid: got %b expected 0010", bus.out_valid); end
        checks++; if (xfer_count !== exp_cnt) begin errors++; $display("[TB] FAIL drain_load_count: got %0d expected %0d", xfer_count, exp_cnt); end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
    endtask

    task automatic test_wrap();
        logic [7:0] start_cnt;
        start_cnt = m_count;
        for (int i = 0; i < 256; i++) begin
            drive(1'b0, 1'b1, 2'(i), $urandom, 4'b1111);
        end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b1111);
        checks++; if (xfer_count !== start_cnt) begin errors++; $display("[TB] FAIL wrap_count: got %0d expected %0d", xfer_count, start_cnt); end
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL wrap_valid: got %b expected 0000", bus.out_valid); end
    endtask

    task automatic test_idle();
        logic [7:0] base;
        base = m_count;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 2'(i), $urandom, (i % 2 == 1) ? 4'b1010 : 4'b0101);
            checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL idle_valid%0d: got %b expected 0000", i, bus.out_valid); end
            checks++; if (xfer_count !== base) begin errors++; $display("[TB] FAIL idle_count%0d: got %0d expected %0d", i, xfer_count, base); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 2'(k), 32'hC0DE_0000 + 32'(k), 4'b0000);
        end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        checks++; if (bus.out_valid !== 4'b1111) begin errors++; $display("[TB] FAIL rmid_full: got %b expected 1111", bus.out_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rmid_busy: got %b expected 1", busy); end
        drive(1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 4'b1111);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_in_ready: got %b expected 0", bus.in_ready); end
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        checks++; if (bus.out_valid !== 4'b0000) begin errors++; $display("[TB] FAIL rmid_valid: got %b expected 0000", bus.out_valid); end
        checks++; if (xfer_count !== 8'd0) begin errors++; $display("[TB] FAIL rmid_count: got %0d expected 0", xfer_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_busy_clr: got %b expected 0", busy); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (r_arr[k] !== 32'h0) begin errors++; $display("[TB] FAIL rmid_R%0d: got %h expected 0", k, r_arr[k]); end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.S0        = 1'b0;
        bus.S1        = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        $display("[TB] starting demux_1x4_buffered bench");
        test_reset();
        test_routing();
        test_stall();
        test_drain_load();
        test_wrap();
        test_idle();
        test_reset_mid();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 4'b0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
